fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the single-cycle core. It owns the program counter and drives a variable-latency instruction memory through a req/ack handshake. It delivers each fetched instruction to decode with a valid/stall handshake and applies branch/jump redirects from execute, including redirects that arrive while a fetch is in flight. It also detects the program-end halt loop and flags memory timeouts.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer (PC, req/ack memory side, valid/stall decode side).
// Define FETCH_CTRL_HALT_DET_EN to stop fetching once HALT_PC has been consumed.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_005c,
  parameter logic [31:0] HALT_PC        = 32'h0000_0094,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc,
  output logic        halted,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DELIVER,
`ifdef FETCH_CTRL_HALT_DET_EN
    HALT,
`endif
    ERROR
  } state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_pc;
  logic [15:0] wait_cnt;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'd3;
  assign imem_addr    = pc;

`ifndef FETCH_CTRL_HALT_DET_EN
  // Halt detection compiled out: the flag is constant low.
  assign halted = 1'b0 & (inst_pc == HALT_PC);
`endif

  // A redirect seen while a fetch is outstanding is parked in pend_pc; the word
  // returned for the stale address is then dropped and the fetch restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= 32'd0;
      inst_pc     <= 32'd0;
      timeout_err <= 1'b0;
      pend        <= 1'b0;
      pend_pc     <= 32'd0;
      wait_cnt    <= 16'd0;
`ifdef FETCH_CTRL_HALT_DET_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= 16'd0;
        end
        FETCH: begin
          if (imem_ack) begin
            wait_cnt <= 16'd0;
            if (redirect_valid || pend) begin
              pc   <= redirect_valid ? redirect_tgt : pend_pc;
              pend <= 1'b0;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              imem_req   <= 1'b0;
              state      <= DELIVER;
            end
          end else if (wait_cnt + 16'd1 == TIMEOUT_CYCLES) begin
            state       <= ERROR;
            imem_req    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (redirect_valid) begin
              pend    <= 1'b1;
              pend_pc <= redirect_tgt;
            end
          end
        end
        DELIVER: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_tgt;
            imem_req   <= 1'b1;
            wait_cnt   <= 16'd0;
            state      <= FETCH;
          end else if (!stall) begin
            inst_valid <= 1'b0;
`ifdef FETCH_CTRL_HALT_DET_EN
            if (inst_pc == HALT_PC) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc       <= pc + 32'd4;
              imem_req <= 1'b1;
              wait_cnt <= 16'd0;
              state    <= FETCH;
            end
`else
            pc       <= pc + 32'd4;
            imem_req <= 1'b1;
            wait_cnt <= 16'd0;
            state    <= FETCH;
`endif
          end
        end
`ifdef FETCH_CTRL_HALT_DET_EN
        HALT: begin
          imem_req <= 1'b0;
        end
`endif
        ERROR: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized memory latency, redirects and stalls; a transaction-level
// model queues expected fetch requests and deliveries, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_005c;
  localparam logic [31:0] HALT_PC  = 32'h0000_0094;
  localparam logic [15:0] TMO      = 16'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req, inst_valid, halted, timeout_err;
  logic [31:0] imem_addr, inst, inst_pc, pc;

  fetch_ctrl #(.RESET_PC(RESET_PC), .HALT_PC(HALT_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .pc(pc), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] addr; } req_exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] word; } dlv_exp_t;

  req_exp_t req_q[$];
  dlv_exp_t dlv_q[$];
  int cyc = 0, total = 0, bad = 0;
  int halt_cyc = -1, err_cyc = -1;
  logic in_reset = 1'b1;

  // Driver-side model of the architectural fetch stream
  int lat, wait_n, redir_pct = 0, force_lat = -1;
  logic fetch_active = 1'b0, redir_seen = 1'b0, no_ack = 1'b0;
  logic [31:0] pend_tgt = 32'd0, model_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s cycle=%0d", name, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    in_reset = 1'b1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    repeat (2) next_cycle();
    check_output("rst_pc", pc, RESET_PC);
    check_output("rst_addr", imem_addr, RESET_PC);
    check_output("rst_req", {31'd0, imem_req}, 32'd0);
    check_output("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_output("rst_inst", inst, 32'd0);
    check_output("rst_inst_pc", inst_pc, 32'd0);
    check_output("rst_halted", {31'd0, halted}, 32'd0);
    check_output("rst_timeout", {31'd0, timeout_err}, 32'd0);
    req_q.delete();
    dlv_q.delete();
    halt_cyc = -1;
    err_cyc = -1;
    fetch_active = 1'b0;
    model_pc = RESET_PC;
    rst = 1'b0;
    // A stray response while idle must be ignored
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    req_q.push_back('{cyc + 1, RESET_PC});
    in_reset = 1'b0;
  endtask

  task automatic apply_stimulus();
    logic do_redir;
    logic [31:0] tgt;
    next_cycle();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    stall = ($urandom_range(0, 1) == 1);
    imem_rdata = $urandom;
    do_redir = ($urandom_range(0, 99) < redir_pct);
    tgt = 32'($urandom_range(0, 4095));
    if (imem_req) begin
      if (!fetch_active) begin
        fetch_active = 1'b1;
        wait_n = 0;
        redir_seen = 1'b0;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      if (do_redir) begin
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        redir_seen = 1'b1;
        pend_tgt = tgt & ~32'd3;
      end
      if (!no_ack && wait_n == lat) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        fetch_active = 1'b0;
        if (redir_seen) begin
          model_pc = pend_tgt;
          req_q.push_back('{cyc + 1, model_pc});
        end else begin
          dlv_q.push_back('{cyc + 1, model_pc, mem_word(model_pc)});
        end
      end
      wait_n++;
    end else if (inst_valid) begin
      if (do_redir) begin
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        model_pc = tgt & ~32'd3;
        req_q.push_back('{cyc + 1, model_pc});
      end else if (!stall) begin
`ifdef FETCH_CTRL_HALT_DET_EN
        if (model_pc == HALT_PC) halt_cyc = cyc + 1;
        else begin
          model_pc = model_pc + 32'd4;
          req_q.push_back('{cyc + 1, model_pc});
        end
`else
        model_pc = model_pc + 32'd4;
        req_q.push_back('{cyc + 1, model_pc});
`endif
      end
    end else if (halt_cyc >= 0 && $urandom_range(0, 1) == 1) begin
      redirect_valid = 1'b1;
      redirect_pc = tgt;
    end
  endtask

  // Monitor: pops expectations when the DUT starts a request or presents an instruction
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, have_dlv = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  req_exp_t e_req;
  dlv_exp_t cur_dlv;

  always @(negedge clk) begin
    if (!in_reset) begin
      if (imem_req && (!prev_req || prev_ack)) begin
        if (req_q.size() == 0) report_fail("unexpected_req");
        else begin
          e_req = req_q.pop_front();
          check_output("req_cycle", cyc, e_req.cyc);
          check_output("req_addr", imem_addr, e_req.addr);
          cur_addr = e_req.addr;
        end
      end else if (imem_req) begin
        check_output("addr_hold", imem_addr, cur_addr);
      end
      if (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        report_fail("missing_req");
        void'(req_q.pop_front());
      end
      if (inst_valid && !prev_valid) begin
        if (dlv_q.size() == 0) begin
          report_fail("unexpected_valid");
          have_dlv = 1'b0;
        end else begin
          cur_dlv = dlv_q.pop_front();
          have_dlv = 1'b1;
          check_output("valid_cycle", cyc, cur_dlv.cyc);
        end
      end
      if (inst_valid && have_dlv) begin
        check_output("inst_pc", inst_pc, cur_dlv.addr);
        check_output("inst", inst, cur_dlv.word);
      end
      if (dlv_q.size() > 0 && dlv_q[0].cyc < cyc) begin
        report_fail("missing_valid");
        void'(dlv_q.pop_front());
      end
      if (halt_cyc >= 0 && cyc >= halt_cyc) begin
        check_output("halted", {31'd0, halted}, 32'd1);
        check_output("halt_req", {31'd0, imem_req}, 32'd0);
        check_output("halt_pc", pc, HALT_PC);
      end else begin
        check_output("not_halted", {31'd0, halted}, 32'd0);
      end
      if (err_cyc >= 0 && cyc >= err_cyc) begin
        check_output("timeout_err", {31'd0, timeout_err}, 32'd1);
        check_output("err_req", {31'd0, imem_req}, 32'd0);
        check_output("err_valid", {31'd0, inst_valid}, 32'd0);
      end else begin
        check_output("no_timeout", {31'd0, timeout_err}, 32'd0);
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_valid = inst_valid;
    end else begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_valid = 1'b0;
      have_dlv = 1'b0;
    end
  end

  initial begin
    $display("[TB] sequential fetch from reset through HALT_PC");
    redir_pct = 0;
    apply_reset();
    repeat (120) apply_stimulus();

    $display("[TB] ack on the last allowed request cycle");
    force_lat = 3;
    apply_reset();
    repeat (60) apply_stimulus();
    force_lat = -1;

    $display("[TB] random redirects, stalls and latencies");
    for (int r = 0; r < 6; r++) begin
      redir_pct = 15 + r * 5;
      apply_reset();
      repeat (400) apply_stimulus();
    end

    $display("[TB] memory timeout");
    redir_pct = 0;
    no_ack = 1'b1;
    apply_reset();
    err_cyc = cyc + 5;
    repeat (12) apply_stimulus();
    no_ack = 1'b0;

    @(negedge clk);
    check_output("req_q_empty", req_q.size(), 32'd0);
    check_output("dlv_q_empty", dlv_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
